// File: rtl/coin_sched_if.sv
// Bundles the requester-facing handshake and generator signals of coin_sched.
// The requester side (master) drives requests, coin_ready, and the generator
// register values. The scheduler (slave) drives grants, the coin stream, and
// the generator controls.
interface coin_sched_if #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 12
);
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_reseed;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  coin_valid;
  logic [15:0]           coin_data;
  logic                  coin_ready;
  logic                  coin_last;
  logic                  done;
  logic                  gen_step;
  logic                  gen_reseed;
  logic [7:0]            gen_coins_a;
  logic [7:0]            gen_coins_b;

  modport master (
    output req, req_len, req_reseed, coin_ready, gen_coins_a, gen_coins_b,
    input  gnt, busy, coin_valid, coin_data, coin_last, done, gen_step, gen_reseed
  );

  modport slave (
    input  req, req_len, req_reseed, coin_ready, gen_coins_a, gen_coins_b,
    output gnt, busy, coin_valid, coin_data, coin_last, done, gen_step, gen_reseed
  );
endinterface

// File: rtl/coin_sched.sv
// Round-robin scheduler for the shared dual 8-bit coin generator. It grants
// one requester at a time, optionally reseeds the generator, and then streams
// exactly the requested number of 16-bit coin words. Each accepted word
// advances the generator once.
module coin_sched #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  coin_sched_if.slave  bus
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESEED,
    ST_STREAM,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [LEN_W-1:0]   pick_len;
  logic               stream_act;
  logic               handshake;

  // Search for the first active request, starting at the round-robin pointer.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and infers a latch.
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && bus.req[(int'(rr_q) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign pick_len = bus.req_len[int'(pick_idx)*LEN_W +: LEN_W];

  // The reset cycle itself must not present data or move the generator.
  assign stream_act = (state_q == ST_STREAM) && !rst;
  assign handshake  = (state_q == ST_STREAM) && bus.coin_ready;

  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.coin_valid = stream_act;
  assign bus.coin_last  = stream_act && (cnt_q == LEN_W'(1));
  assign bus.coin_data  = stream_act ? {bus.gen_coins_b, bus.gen_coins_a} : 16'h0000;
  assign bus.gen_step   = stream_act && bus.coin_ready;
  assign bus.gen_reseed = (state_q == ST_RESEED) && !rst;
  assign bus.done       = (state_q == ST_DONE) && !rst;

  // Next-state logic: arbitration in IDLE, then reseed/stream/done sequencing.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          cnt_d           = pick_len;
          win_d           = pick_idx;
          if (bus.req_reseed[pick_idx])  state_d = ST_RESEED;
          else if (pick_len == '0)       state_d = ST_DONE;
          else                           state_d = ST_STREAM;
        end
      end
      ST_RESEED: begin
        state_d = (cnt_q == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        rr_d    = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register updates from the same pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_coin_sched.sv
// Self-checking bench for coin_sched. A behavioural LFSR generator sits next
// to the DUT. A transaction-level reference model predicts the winner, the
// cycle-by-cycle phases, and the coin words.
module tb_coin_sched;

  localparam int NREQ = 2;
  localparam int LW   = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coin_sched_if #(.NREQ(NREQ), .LEN_W(LW)) bus ();

  coin_sched #(.NREQ(NREQ), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Fibonacci LFSR, taps 8,6,5,4. It shifts toward bit 8, and the new bit enters bit 1.
  function automatic logic [7:0] lfsr8(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  // Behavioural coin generator driven by the DUT's step/reseed controls.
  logic [7:0] gen_a = 8'hA5;
  logic [7:0] gen_b = 8'h3C;
  always @(posedge clk) begin
    if (bus.gen_reseed) begin
      gen_a <= 8'hFF;
      gen_b <= 8'h01;
    end else if (bus.gen_step) begin
      gen_a <= lfsr8(gen_a);
      gen_b <= lfsr8(gen_b);
    end
  end
  assign bus.gen_coins_a = gen_a;
  assign bus.gen_coins_b = gen_b;

  // Reference-model state: the expected generator contents and the round-robin pointer.
  logic [7:0] ref_a = 8'hA5;
  logic [7:0] ref_b = 8'h3C;
  int rr_m = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [2*LW-1:0] mk_len(input int l0, input int l1);
    return {LW'(l1), LW'(l0)};
  endfunction

  // The observed control outputs: {gnt, busy, valid, last, done, step, reseed}.
  function automatic logic [7:0] obs();
    return {bus.gnt, bus.busy, bus.coin_valid, bus.coin_last, bus.done,
            bus.gen_step, bus.gen_reseed};
  endfunction

  // One full transaction. The model predicts the winner and the phase sequence
  // (idle, optional reseed, len words, done). It compares every cycle.
  task automatic do_txn(input logic [NREQ-1:0] req_v, input logic [2*LW-1:0] len_v,
                        input logic [NREQ-1:0] rs_v, input logic [NREQ-1:0] req_mid,
                        input int rmode, input string tag);
    int win, len, left, cyc, zeros;
    bit rs, rdy;
    logic [1:0] oh;
    logic [7:0] exp_v;
    win  = pick(req_v, rr_m);
    len  = int'(len_v[win*LW +: LW]);
    rs   = rs_v[win];
    oh   = 2'b01 << win;
    @(negedge clk);
    bus.req = req_v; bus.req_len = len_v; bus.req_reseed = rs_v; bus.coin_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_bad++;
      $display("FAIL %s idle: got %b want %b", tag, obs(), 8'h00);
    end
    if (rs) begin
      @(negedge clk);
      bus.req = req_mid; bus.coin_ready = 1'b1;
      #1;
      exp_v = {oh, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL %s reseed: got %b want %b", tag, obs(), exp_v);
      end
      ref_a = 8'hFF;
      ref_b = 8'h01;
    end
    left = len; cyc = 0; zeros = 0;
    while (left > 0) begin
      @(negedge clk);
      bus.req = req_mid;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
        default: rdy = (zeros >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      zeros = rdy ? 0 : zeros + 1;
      bus.coin_ready = rdy;
      #1;
      exp_v = {oh, 1'b1, 1'b1, (left == 1), 1'b0, rdy, 1'b0};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL %s ctl cyc%0d: got %b want %b", tag, cyc, obs(), exp_v);
      end
      n_cmp++;
      if (bus.coin_data !== {ref_b, ref_a}) begin
        n_bad++;
        $display("FAIL %s data cyc%0d: got %h want %h", tag, cyc, bus.coin_data, {ref_b, ref_a});
      end
      if (rdy) begin
        ref_a = lfsr8(ref_a);
        ref_b = lfsr8(ref_b);
        left--;
      end
      cyc++;
    end
    @(negedge clk);
    bus.req = req_mid; bus.coin_ready = 1'b1;
    #1;
    exp_v = {oh, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++;
      $display("FAIL %s done: got %b want %b", tag, obs(), exp_v);
    end
    rr_m = (win + 1) % NREQ;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_len = '0; bus.req_reseed = '0; bus.coin_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (obs() !== 8'h00 || bus.coin_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_hold: got %b/%h want 0/0", obs(), bus.coin_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_release: got %b want 0", obs());
    end
    rr_m = 0;
  endtask

  task automatic test_reseed_stream();
    do_txn(2'b01, mk_len(3, 0), 2'b01, 2'b01, 0, "reseed_stream");
  endtask

  task automatic test_stall();
    do_txn(2'b01, mk_len(3, 0), 2'b01, 2'b01, 1, "stall");
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    do_txn(2'b11, mk_len(2, 2), 2'b00, 2'b11, 0, "b2b_first");
    do_txn(2'b11, mk_len(2, 2), 2'b00, 2'b00, 0, "b2b_second");
  endtask

  task automatic test_len_zero();
    do_txn(2'b10, mk_len(0, 0), 2'b00, 2'b00, 0, "len_zero");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.req = 2'b01; bus.req_len = mk_len(5, 0); bus.req_reseed = 2'b00; bus.coin_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.coin_valid !== 1'b1 || bus.coin_data !== {ref_b, ref_a}) begin
      n_bad++;
      $display("FAIL abort_word1: got v=%b %h want v=1 %h", bus.coin_valid, bus.coin_data, {ref_b, ref_a});
    end
    ref_a = lfsr8(ref_a);
    ref_b = lfsr8(ref_b);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.gen_step !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_step: got %b want 0", bus.gen_step);
    end
    @(negedge clk);
    rst = 1'b0; bus.req = '0;
    #1;
    n_cmp++;
    if (obs() !== 8'h00 || bus.coin_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL abort_cleared: got %b/%h want 0/0", obs(), bus.coin_data);
    end
    rr_m = 0;
    do_txn(2'b10, mk_len(0, 2), 2'b00, 2'b00, 0, "after_abort");
  endtask

  task automatic test_req_drop();
    do_txn(2'b01, mk_len(4, 0), 2'b00, 2'b00, 2, "req_drop");
  endtask

  task automatic test_max_len();
    do_txn(2'b01, mk_len(4095, 0), 2'b01, 2'b00, 0, "max_len");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r, rs, mid;
    for (int it = 0; it < 30; it++) begin
      r   = NREQ'($urandom_range(1, 3));
      rs  = NREQ'($urandom_range(0, 3));
      mid = NREQ'($urandom_range(0, 3));
      do_txn(r, mk_len($urandom_range(0, 7), $urandom_range(0, 7)), rs, mid, 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_reseed_stream();
    test_stall();
    test_back_to_back();
    test_len_zero();
    test_reset_abort();
    test_req_drop();
    test_max_len();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
